// File: rtl/shufflenet_sched_pkg.sv
// Shared types, widths and the per-stage kernel table for the ShuffleNet stage sequencer.
package shufflenet_sched_pkg;

  localparam int unsigned STAGE_W = 6;
  localparam int unsigned KCNT_W  = 5;

  localparam logic [STAGE_W-1:0] LAST_STAGE = 6'd37;
  localparam logic [STAGE_W-1:0] END_STAGE  = 6'd38;

  typedef struct packed {
    logic [4:0] num_kernels;
    logic [4:0] row_size;
  } stage_cfg_t;

  typedef enum logic [2:0] {IDLE, LOAD, READ, WAIT, FINISH} seq_state_t;

  // Entries of {0,0} are non-conv stages and get skipped; num_kernels*row_size never exceeds 64.
  localparam stage_cfg_t STAGE_CFG [0:63] = '{
    1:  '{5'd16, 5'd2},  3:  '{5'd2,  5'd4},  4:  '{5'd4,  5'd4},  5:  '{5'd8,  5'd2},
    6:  '{5'd4,  5'd1},  7:  '{5'd8,  5'd4},  8:  '{5'd1,  5'd1},  9:  '{5'd16, 5'd4},
    10: '{5'd2,  5'd8},  13: '{5'd4,  5'd4},  14: '{5'd8,  5'd8},  15: '{5'd16, 5'd2},
    16: '{5'd4,  5'd2},  17: '{5'd8,  5'd1},  18: '{5'd2,  5'd2},  19: '{5'd4,  5'd8},
    20: '{5'd16, 5'd1},  21: '{5'd1,  5'd16}, 22: '{5'd8,  5'd4},  24: '{5'd4,  5'd4},
    25: '{5'd2,  5'd16}, 26: '{5'd8,  5'd2},  27: '{5'd16, 5'd4},  28: '{5'd4,  5'd2},
    30: '{5'd8,  5'd8},  31: '{5'd2,  5'd2},  32: '{5'd4,  5'd4},  33: '{5'd16, 5'd1},
    34: '{5'd1,  5'd1},  37: '{5'd8,  5'd4},
    default: '{5'd0, 5'd0}
  };

endpackage

// File: rtl/conv_stage_sequencer_if.sv
// Sequencer <-> kernel_control handshake: start/result-ready in, stage/kernel/enable/status out.
interface conv_stage_sequencer_if;
  import shufflenet_sched_pkg::*;

  logic               start;
  logic               cnn_result_ready;
  logic [STAGE_W-1:0] stage_count_next;
  logic [KCNT_W-1:0]  kernel_count_next;
  logic               read_kernel_enable;
  logic               busy;
  logic               done;

  modport master (
    input  start, cnn_result_ready,
    output stage_count_next, kernel_count_next, read_kernel_enable, busy, done
  );

  modport slave (
    output start, cnn_result_ready,
    input  stage_count_next, kernel_count_next, read_kernel_enable, busy, done
  );

endinterface

// File: rtl/stage_row_counter.sv
// Kernel/row counter for one stage; a step from kernel 0 loads kernel 1, row 0.
module stage_row_counter
  import shufflenet_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [KCNT_W-1:0] num_kernels,
  input  logic [KCNT_W-1:0] row_size,
  output logic [KCNT_W-1:0] kernel,
  output logic              last_row,
  output logic              last_kernel
);

  logic [KCNT_W-1:0] row_q, row_d;
  logic [KCNT_W-1:0] kernel_q, kernel_d;

  assign last_row    = (row_q == row_size - KCNT_W'(1));
  assign last_kernel = (kernel_q == num_kernels);
  assign kernel      = kernel_q;

  always_comb begin
    row_d    = row_q;
    kernel_d = kernel_q;
    if (clear) begin
      row_d    = '0;
      kernel_d = '0;
    end else if (step) begin
      if (kernel_q == '0) begin
        row_d    = '0;
        kernel_d = KCNT_W'(1);
      end else if (last_row) begin
        row_d = '0;
        // Final kernel holds its value so WAIT still shows it.
        if (!last_kernel) kernel_d = kernel_q + KCNT_W'(1);
      end else begin
        row_d = row_q + KCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q    <= '0;
      kernel_q <= '0;
    end else begin
      row_q    <= row_d;
      kernel_q <= kernel_d;
    end
  end

endmodule

// File: rtl/conv_stage_sequencer.sv
// Walks stages 1..LAST_STAGE, issuing each kernel's rows and waiting for the result per stage.
module conv_stage_sequencer
  import shufflenet_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  conv_stage_sequencer_if.master bus
);

  seq_state_t         state_q;
  logic [STAGE_W-1:0] stage_q;
  logic               ren_q, busy_q, done_q;

  stage_cfg_t        cfg;
  logic              skip, ctr_clear, ctr_step, last_row, last_kernel;
  logic [KCNT_W-1:0] kernel;

  assign cfg  = STAGE_CFG[stage_q];
  assign skip = (cfg.num_kernels == '0) || (cfg.row_size == '0);

  assign ctr_clear = (state_q == IDLE) || (state_q == FINISH) ||
                     ((state_q == WAIT) && bus.cnn_result_ready);
  assign ctr_step  = ((state_q == LOAD) && !skip) || (state_q == READ);

  stage_row_counter u_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (ctr_clear),
    .step       (ctr_step),
    .num_kernels(cfg.num_kernels),
    .row_size   (cfg.row_size),
    .kernel     (kernel),
    .last_row   (last_row),
    .last_kernel(last_kernel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            stage_q <= STAGE_W'(1);
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (!skip) begin
            ren_q   <= 1'b1;
            state_q <= READ;
          end else if (stage_q == LAST_STAGE) begin
            stage_q <= END_STAGE;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            stage_q <= stage_q + STAGE_W'(1);
          end
        end
        READ: begin
          if (last_row && last_kernel) begin
            ren_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.cnn_result_ready) begin
            if (stage_q == LAST_STAGE) begin
              stage_q <= END_STAGE;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              stage_q <= stage_q + STAGE_W'(1);
              state_q <= LOAD;
            end
          end
        end
        FINISH: begin
          stage_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stage_count_next   = stage_q;
  assign bus.kernel_count_next  = kernel;
  assign bus.read_kernel_enable = ren_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;

endmodule

// File: tb/tb_conv_stage_sequencer.sv
// Directed bench for conv_stage_sequencer; enable cycles are checked against a (stage, kernel) queue.
module tb_conv_stage_sequencer;
  import shufflenet_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_stage_sequencer_if bus ();

  conv_stage_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0, passed = 0, failed = 0;
  int exp_q[$];
  int stage_log[$];
  int prev_stage = 0;
  int cnt38 = 0, cnt_done = 0;
  bit sb_on = 1'b1;

  function automatic int st(); return int'(bus.stage_count_next); endfunction
  function automatic int kn(); return int'(bus.kernel_count_next); endfunction
  function automatic int en(); return int'(bus.read_kernel_enable); endfunction
  function automatic int bz(); return int'(bus.busy); endfunction
  function automatic int dn(); return int'(bus.done); endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push_stage(input int s, input int nk, input int rs);
    for (int k = 1; k <= nk; k++)
      for (int r = 0; r < rs; r++) exp_q.push_back(s * 256 + k);
  endfunction

  // Queue the enables of the next conv stage after s; 0 when the run finishes instead.
  function automatic int push_next(input int s);
    for (int t = s + 1; t <= int'(LAST_STAGE); t++) begin
      if (STAGE_CFG[t].num_kernels != 5'd0 && STAGE_CFG[t].row_size != 5'd0) begin
        push_stage(t, int'(STAGE_CFG[t].num_kernels), int'(STAGE_CFG[t].row_size));
        return t;
      end
    end
    return 0;
  endfunction

  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    if (st() != prev_stage) begin
      stage_log.push_back(st());
      prev_stage = st();
    end
    if (st() == int'(END_STAGE)) cnt38++;
    if (dn() == 1) cnt_done++;
    if (sb_on && en() == 1) begin
      if (exp_q.size() == 0) chk("sb_extra_enable", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_stage", st(), e / 256);
        chk("sb_kernel", kn(), e % 256);
      end
    end
  endtask

  // Starting from a sampled LOAD cycle, count enable cycles until the first cycle without one.
  task automatic count_en(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (en() == 1) n++;
      else break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cur, nxt, fin, ok;

    // 1: reset held low with start high
    reset = 1'b0;
    bus.start = 1'b1;
    bus.cnn_result_ready = 1'b0;
    repeat (3) tick();
    chk("rst_stage", st(), 0);
    chk("rst_kernel", kn(), 0);
    chk("rst_enable", en(), 0);
    chk("rst_busy", bz(), 0);
    chk("rst_done", dn(), 0);
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_stage", st(), 0);
    chk("idle_busy", bz(), 0);

    // 2: stage 1 = 16 kernels x 2 rows
    bus.start = 1'b1;
    bus.cnn_result_ready = 1'b1;
    push_stage(1, 16, 2);
    tick();
    bus.start = 1'b0;
    bus.cnn_result_ready = 1'b0;
    chk("load1_stage", st(), 1);
    chk("load1_enable", en(), 0);
    chk("load1_kernel", kn(), 0);
    chk("load1_busy", bz(), 1);
    count_en(n);
    chk("s1_enables", n, 32);
    chk("s1_wait_stage", st(), 1);
    chk("s1_wait_kernel", kn(), 16);
    repeat (4) tick();
    chk("s1_wait_hold", st(), 1);

    // 3: stage 2 skipped, stage 3 = 2 kernels x 4 rows
    bus.cnn_result_ready = 1'b1;
    push_stage(3, 2, 4);
    tick();
    bus.cnn_result_ready = 1'b0;
    chk("skip2_stage", st(), 2);
    chk("skip2_enable", en(), 0);
    tick();
    chk("load3_stage", st(), 3);
    chk("load3_kernel", kn(), 0);
    count_en(n);
    chk("s3_enables", n, 8);
    chk("s3_wait_kernel", kn(), 2);
    chk("s3_queue_empty", exp_q.size(), 0);

    // asynchronous reset takes effect without a clock edge
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_stage", st(), 0);
    chk("async_rst_busy", bz(), 0);
    tick();
    reset = 1'b1;

    // 4: result-ready held through stage 1 READ
    stage_log.delete();
    prev_stage = 0;
    cnt38 = 0;
    cnt_done = 0;
    bus.start = 1'b1;
    push_stage(1, 16, 2);
    tick();
    bus.start = 1'b0;
    bus.cnn_result_ready = 1'b1;
    count_en(n);
    chk("rdy_s1_enables", n, 32);
    chk("rdy_wait_stage", st(), 1);
    chk("rdy_wait_kernel", kn(), 16);
    bus.cnn_result_ready = 1'b0;

    // 5: full run, result-ready pulsed 3 cycles after each WAIT entry
    cur = 1;
    fin = 0;
    for (int guard = 0; guard < 45 && fin == 0; guard++) begin
      repeat (2) tick();
      chk("wait_hold_stage", st(), cur);
      chk("wait_hold_enable", en(), 0);
      bus.cnn_result_ready = 1'b1;
      nxt = push_next(cur);
      tick();
      bus.cnn_result_ready = 1'b0;
      if (nxt == 0) begin
        chk("finish_stage", st(), int'(END_STAGE));
        chk("finish_done", dn(), 1);
        chk("finish_kernel", kn(), 0);
        tick();
        chk("post_stage", st(), 0);
        chk("post_busy", bz(), 0);
        chk("post_done", dn(), 0);
        fin = 1;
      end else begin
        ok = 0;
        for (int i = 0; i < 64; i++) begin
          if (en() == 1) begin ok = 1; break; end
          tick();
        end
        chk("reach_read", ok, 1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
          if (en() == 0) begin ok = 1; break; end
          tick();
        end
        chk("reach_wait", ok, 1);
        chk("wait_stage", st(), nxt);
        chk("wait_kernel", kn(), int'(STAGE_CFG[nxt].num_kernels));
        cur = nxt;
      end
    end
    chk("run_finished", fin, 1);
    chk("run_queue_empty", exp_q.size(), 0);
    chk("stage38_cycles", cnt38, 1);
    chk("done_cycles", cnt_done, 1);
    chk("stage_log_len", stage_log.size(), 39);
    for (int i = 0; i < stage_log.size() && i < 39; i++)
      chk("stage_log", stage_log[i], (i < 38) ? i + 1 : 0);

    // 6: reset during stage 7 READ, then restart
    sb_on = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.cnn_result_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (st() == 7 && en() == 1) begin ok = 1; break; end
      tick();
    end
    chk("reach_s7_read", ok, 1);
    repeat (2) tick();
    bus.cnn_result_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_stage", st(), 0);
    chk("mid_rst_kernel", kn(), 0);
    chk("mid_rst_enable", en(), 0);
    chk("mid_rst_busy", bz(), 0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("restart_idle", st(), 0);
    sb_on = 1'b1;
    bus.start = 1'b1;
    push_stage(1, 16, 2);
    tick();
    bus.start = 1'b0;
    chk("restart_stage", st(), 1);
    chk("restart_kernel", kn(), 0);
    chk("restart_enable", en(), 0);
    count_en(n);
    chk("restart_enables", n, 32);
    chk("restart_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
